// File: rtl/io_port_bridge_pkg.sv
// Shared constants for the processor/host byte bridge: depth default,
// pointer width helper and Status bit positions.
package io_port_bridge_pkg;

  localparam int DEPTH_DEFAULT = 4;

  localparam int ST_OUT_EMPTY    = 0;
  localparam int ST_IN_FULL      = 1;
  localparam int ST_OUT_OVERFLOW = 2;
  localparam int ST_IN_UNDERFLOW = 3;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/io_port_bridge_byte_fifo.sv
// In-order byte FIFO, head visible combinationally (8'h00 when empty).
// Push while full is accepted only when a pop happens in the same cycle.
module io_port_bridge_byte_fifo
  import io_port_bridge_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [7:0]       data_i,
  output logic [7:0]       data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/io_port_bridge.sv
// Processor <-> host byte bridge: input FIFO (host to processor) and output
// FIFO (processor to host), sticky error flags and registered interrupt.
module io_port_bridge
  import io_port_bridge_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Data_out,
  input  logic       Out_Strobe,
  output logic [7:0] Data_in,
  input  logic       In_Strobe,
  input  logic [7:0] Host_In_Data,
  input  logic       Host_In_Valid,
  output logic       Host_In_Ready,
  output logic [7:0] Host_Out_Data,
  output logic       Host_Out_Valid,
  input  logic       Host_Out_Ready,
  input  logic       Int_En,
  output logic       Interrupt,
  input  logic       Clear_Flags,
  output logic [3:0] Status
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic             in_full, in_empty;
  logic [PTR_W:0]   in_count;
  logic             out_full, out_empty;
  logic [PTR_W:0]   out_count;

  logic             in_push, in_pop, out_push, host_pop;
  logic             in_underflow_ev, out_overflow_ev;
  logic             in_underflow_q, in_underflow_d;
  logic             out_overflow_q, out_overflow_d;
  logic             interrupt_q, interrupt_d;

  // Ready comes from the registered count only, so a same-cycle pop
  // cannot open room for a push.
  assign Host_In_Ready   = !in_full;
  assign in_push         = Host_In_Valid && !in_full;
  assign in_pop          = In_Strobe && !in_empty;
  assign in_underflow_ev = In_Strobe && in_empty;

  assign Host_Out_Valid  = (out_count != '0);
  assign host_pop        = Host_Out_Ready && !out_empty;
  assign out_push        = Out_Strobe && (!out_full || host_pop);
  assign out_overflow_ev = Out_Strobe && out_full && !host_pop;

  io_port_bridge_byte_fifo #(.DEPTH(DEPTH)) u_in_fifo (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .push_i  (in_push),
    .pop_i   (in_pop),
    .data_i  (Host_In_Data),
    .data_o  (Data_in),
    .full_o  (in_full),
    .empty_o (in_empty),
    .count_o (in_count)
  );

  io_port_bridge_byte_fifo #(.DEPTH(DEPTH)) u_out_fifo (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .push_i  (out_push),
    .pop_i   (host_pop),
    .data_i  (Data_out),
    .data_o  (Host_Out_Data),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_count)
  );

  // A fresh error in the clearing cycle keeps its flag set.
  always_comb begin
    in_underflow_d = (in_underflow_q && !Clear_Flags) || in_underflow_ev;
    out_overflow_d = (out_overflow_q && !Clear_Flags) || out_overflow_ev;
    interrupt_d    = Int_En && (in_count != '0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_underflow_q <= 1'b0;
      out_overflow_q <= 1'b0;
      interrupt_q    <= 1'b0;
    end else begin
      in_underflow_q <= in_underflow_d;
      out_overflow_q <= out_overflow_d;
      interrupt_q    <= interrupt_d;
    end
  end

  assign Interrupt = interrupt_q;

  always_comb begin
    Status                  = 4'b0000;
    Status[ST_IN_UNDERFLOW] = in_underflow_q;
    Status[ST_OUT_OVERFLOW] = out_overflow_q;
    Status[ST_IN_FULL]      = in_full;
    Status[ST_OUT_EMPTY]    = out_empty;
  end

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed self-checking bench for io_port_bridge with DEPTH = 4.
module tb_io_port_bridge;

  logic       Clk;
  logic       Reset;
  logic [7:0] Data_out;
  logic       Out_Strobe;
  logic [7:0] Data_in;
  logic       In_Strobe;
  logic [7:0] Host_In_Data;
  logic       Host_In_Valid;
  logic       Host_In_Ready;
  logic [7:0] Host_Out_Data;
  logic       Host_Out_Valid;
  logic       Host_Out_Ready;
  logic       Int_En;
  logic       Interrupt;
  logic       Clear_Flags;
  logic [3:0] Status;

  int total = 0;
  int bad   = 0;

  io_port_bridge #(.DEPTH(4)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Data_out       (Data_out),
    .Out_Strobe     (Out_Strobe),
    .Data_in        (Data_in),
    .In_Strobe      (In_Strobe),
    .Host_In_Data   (Host_In_Data),
    .Host_In_Valid  (Host_In_Valid),
    .Host_In_Ready  (Host_In_Ready),
    .Host_Out_Data  (Host_Out_Data),
    .Host_Out_Valid (Host_Out_Valid),
    .Host_Out_Ready (Host_Out_Ready),
    .Int_En         (Int_En),
    .Interrupt      (Interrupt),
    .Clear_Flags    (Clear_Flags),
    .Status         (Status)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    total++; if (Data_in !== 8'h00) begin bad++; $display("FAIL rst_data_in got=%h exp=00", Data_in); end
    total++; if (Host_In_Ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", Host_In_Ready); end
    total++; if (Host_Out_Valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", Host_Out_Valid); end
    total++; if (Host_Out_Data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h exp=00", Host_Out_Data); end
    total++; if (Status !== 4'b0001) begin bad++; $display("FAIL rst_status got=%b exp=0001", Status); end
    total++; if (Interrupt !== 1'b0) begin bad++; $display("FAIL rst_interrupt got=%b exp=0", Interrupt); end
  endtask

  task automatic test_in_path();
    Host_In_Valid = 1'b1; Host_In_Data = 8'hA5;
    step();
    total++; if (Data_in !== 8'hA5) begin bad++; $display("FAIL in_first got=%h exp=a5", Data_in); end
    Host_In_Data = 8'h3C;
    step();
    Host_In_Valid = 1'b0;
    total++; if (Data_in !== 8'hA5) begin bad++; $display("FAIL in_head_hold got=%h exp=a5", Data_in); end
    In_Strobe = 1'b1;
    step();
    total++; if (Data_in !== 8'h3C) begin bad++; $display("FAIL in_second got=%h exp=3c", Data_in); end
    step();
    In_Strobe = 1'b0;
    total++; if (Data_in !== 8'h00) begin bad++; $display("FAIL in_drained got=%h exp=00", Data_in); end
    total++; if (Status !== 4'b0001) begin bad++; $display("FAIL in_no_underflow got=%b exp=0001", Status); end
  endtask

  task automatic test_in_full();
    logic [7:0] fill [4];
    logic [7:0] drain [4];
    fill  = '{8'h11, 8'h22, 8'h33, 8'h44};
    drain = '{8'h22, 8'h33, 8'h44, 8'h55};
    Host_In_Valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Host_In_Data = fill[i];
      step();
    end
    total++; if (Host_In_Ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", Host_In_Ready); end
    total++; if (Status[1] !== 1'b1) begin bad++; $display("FAIL full_status got=%b exp=1", Status[1]); end
    Host_In_Data = 8'h55;
    step();
    total++; if (Data_in !== 8'h11) begin bad++; $display("FAIL full_held_head got=%h exp=11", Data_in); end
    In_Strobe = 1'b1;
    step();
    In_Strobe = 1'b0;
    total++; if (Host_In_Ready !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop got=%b exp=1", Host_In_Ready); end
    total++; if (Data_in !== 8'h22) begin bad++; $display("FAIL full_head_after_pop got=%h exp=22", Data_in); end
    step();
    Host_In_Valid = 1'b0;
    total++; if (Host_In_Ready !== 1'b0) begin bad++; $display("FAIL full_refill got=%b exp=0", Host_In_Ready); end
    for (int i = 0; i < 4; i++) begin
      total++; if (Data_in !== drain[i]) begin bad++; $display("FAIL wrap_order[%0d] got=%h exp=%h", i, Data_in, drain[i]); end
      In_Strobe = 1'b1;
      step();
      In_Strobe = 1'b0;
    end
    total++; if (Data_in !== 8'h00) begin bad++; $display("FAIL wrap_empty got=%h exp=00", Data_in); end
    total++; if (Status !== 4'b0001) begin bad++; $display("FAIL wrap_status got=%b exp=0001", Status); end
  endtask

  task automatic test_out_overflow();
    Host_Out_Ready = 1'b0;
    Out_Strobe = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      Data_out = 8'(i);
      step();
    end
    Out_Strobe = 1'b0;
    total++; if (Status[2] !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", Status[2]); end
    total++; if (Host_Out_Valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b exp=1", Host_Out_Valid); end
    Host_Out_Ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total++; if (Host_Out_Data !== 8'(i)) begin bad++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, Host_Out_Data, 8'(i)); end
      step();
    end
    Host_Out_Ready = 1'b0;
    total++; if (Host_Out_Valid !== 1'b0) begin bad++; $display("FAIL ovf_valid_end got=%b exp=0", Host_Out_Valid); end
    total++; if (Host_Out_Data !== 8'h00) begin bad++; $display("FAIL ovf_data_end got=%h exp=00", Host_Out_Data); end
    Clear_Flags = 1'b1;
    step();
    Clear_Flags = 1'b0;
    total++; if (Status !== 4'b0001) begin bad++; $display("FAIL ovf_cleared got=%b exp=0001", Status); end
  endtask

  task automatic test_out_full_pop();
    logic [7:0] exp [4];
    exp = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
    Host_Out_Ready = 1'b0;
    Out_Strobe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Data_out = 8'hA0 + 8'(i);
      step();
    end
    Host_Out_Ready = 1'b1;
    Data_out = 8'hB0;
    step();
    Out_Strobe = 1'b0;
    total++; if (Status[2] !== 1'b0) begin bad++; $display("FAIL fullpop_no_ovf got=%b exp=0", Status[2]); end
    for (int i = 0; i < 4; i++) begin
      total++; if (Host_Out_Data !== exp[i]) begin bad++; $display("FAIL fullpop_order[%0d] got=%h exp=%h", i, Host_Out_Data, exp[i]); end
      step();
    end
    Host_Out_Ready = 1'b0;
    total++; if (Host_Out_Valid !== 1'b0) begin bad++; $display("FAIL fullpop_empty got=%b exp=0", Host_Out_Valid); end
  endtask

  task automatic test_underflow();
    In_Strobe = 1'b1;
    step();
    In_Strobe = 1'b0;
    total++; if (Status[3] !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b exp=1", Status[3]); end
    total++; if (Data_in !== 8'h00) begin bad++; $display("FAIL udf_data got=%h exp=00", Data_in); end
    Clear_Flags = 1'b1;
    step();
    total++; if (Status[3] !== 1'b0) begin bad++; $display("FAIL udf_clear got=%b exp=0", Status[3]); end
    In_Strobe = 1'b1;
    step();
    In_Strobe = 1'b0;
    Clear_Flags = 1'b0;
    total++; if (Status[3] !== 1'b1) begin bad++; $display("FAIL udf_error_wins got=%b exp=1", Status[3]); end
    Clear_Flags = 1'b1;
    step();
    Clear_Flags = 1'b0;
    Host_In_Valid = 1'b1; Host_In_Data = 8'h5A; In_Strobe = 1'b1;
    step();
    Host_In_Valid = 1'b0; In_Strobe = 1'b0;
    total++; if (Data_in !== 8'h5A) begin bad++; $display("FAIL push_udf_data got=%h exp=5a", Data_in); end
    total++; if (Status[3] !== 1'b1) begin bad++; $display("FAIL push_udf_flag got=%b exp=1", Status[3]); end
    In_Strobe = 1'b1; Clear_Flags = 1'b1;
    step();
    In_Strobe = 1'b0; Clear_Flags = 1'b0;
    total++; if (Status !== 4'b0001) begin bad++; $display("FAIL push_udf_clean got=%b exp=0001", Status); end
  endtask

  task automatic test_interrupt();
    Int_En = 1'b1;
    Host_In_Valid = 1'b1; Host_In_Data = 8'h7E;
    step();
    Host_In_Valid = 1'b0;
    total++; if (Data_in !== 8'h7E) begin bad++; $display("FAIL irq_data got=%h exp=7e", Data_in); end
    total++; if (Interrupt !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", Interrupt); end
    step();
    total++; if (Interrupt !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1", Interrupt); end
    In_Strobe = 1'b1;
    step();
    In_Strobe = 1'b0;
    total++; if (Interrupt !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b exp=1", Interrupt); end
    step();
    total++; if (Interrupt !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", Interrupt); end
  endtask

  task automatic test_reset_mid();
    Int_En = 1'b1;
    Host_Out_Ready = 1'b0;
    Host_In_Valid = 1'b1; Out_Strobe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Host_In_Data = 8'hC0 + 8'(i);
      Data_out     = 8'hD0 + 8'(i);
      step();
    end
    Host_In_Valid = 1'b0; Out_Strobe = 1'b0;
    total++; if (Interrupt !== 1'b1) begin bad++; $display("FAIL mid_irq_before got=%b exp=1", Interrupt); end
    Reset = 1'b1; In_Strobe = 1'b1; Out_Strobe = 1'b1; Host_In_Valid = 1'b1;
    step();
    Reset = 1'b0; In_Strobe = 1'b0; Out_Strobe = 1'b0; Host_In_Valid = 1'b0;
    total++; if (Status !== 4'b0001) begin bad++; $display("FAIL mid_status got=%b exp=0001", Status); end
    total++; if (Data_in !== 8'h00) begin bad++; $display("FAIL mid_data_in got=%h exp=00", Data_in); end
    total++; if (Host_Out_Valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", Host_Out_Valid); end
    total++; if (Interrupt !== 1'b0) begin bad++; $display("FAIL mid_irq got=%b exp=0", Interrupt); end
    step();
    total++; if (Interrupt !== 1'b0) begin bad++; $display("FAIL mid_irq_after got=%b exp=0", Interrupt); end
  endtask

  initial begin
    Reset = 1'b1;
    Data_out = 8'h00; Out_Strobe = 1'b0; In_Strobe = 1'b0;
    Host_In_Data = 8'h00; Host_In_Valid = 1'b0; Host_Out_Ready = 1'b0;
    Int_En = 1'b0; Clear_Flags = 1'b0;
    step();
    step();
    Reset = 1'b0;
    test_reset();
    test_in_path();
    test_in_full();
    test_out_overflow();
    test_out_full_pop();
    test_underflow();
    test_interrupt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
